stream_serializer: RTL and testbench

//  Consumer for the FIFO read interface (dout/dout_val/dout_rdy). Accepts DataWidth-bit words on a

---
 rtl/stream_serializer.sv | 91 +++++++++
 tb/tb_stream_serializer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_serializer.sv
// Width-down serializer: splits each DataWidth-bit input word into Ratio OutWidth-bit beats.
// Latency 1 cycle from word accept to first beat; input is only ready when idle or on the last beat's handshake.
module stream_serializer #(
  parameter int DataWidth = 16,
  parameter int OutWidth  = 4,
  parameter bit LsbFirst  = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic [DataWidth-1:0] din_i,
  input  logic                 din_val_i,
  output logic                 din_rdy_o,
  output logic [OutWidth-1:0]  dout_o,
  output logic                 dout_val_o,
  input  logic                 dout_rdy_i,
  output logic                 dout_last_o,
  output logic                 busy_o
);

  localparam int Ratio = DataWidth / OutWidth;
  localparam int CntW  = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Ratio - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  logic                 last_q, last_d;
  logic                 out_hs, in_hs;

  assign dout_val_o  = (state_q == SHIFT);
  assign busy_o      = (state_q == SHIFT);
  assign dout_last_o = last_q;
  assign dout_o      = LsbFirst ? shift_q[OutWidth-1:0] : shift_q[DataWidth-1 -: OutWidth];

  // Ready may follow dout_rdy_i combinationally so a new word lands on the last beat's handshake.
  assign out_hs    = dout_val_o & dout_rdy_i;
  assign din_rdy_o = (state_q == IDLE) | (out_hs & last_q);
  assign in_hs     = din_val_i & din_rdy_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (in_hs) begin
          state_d = SHIFT;
          shift_d = din_i;
          cnt_d   = '0;
          last_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (out_hs) begin
          if (!last_q) begin
            shift_d = LsbFirst ? (shift_q >> OutWidth) : (shift_q << OutWidth);
            cnt_d   = cnt_q + CntW'(1);
            last_d  = (cnt_d == LastCnt);
          end else if (in_hs) begin
            shift_d = din_i;
            cnt_d   = '0;
            last_d  = 1'b0;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_stream_serializer.sv
// Bench for stream_serializer: two instances (LSB-first and MSB-first) share stimulus and are
// compared every cycle against a queue-of-beats model, plus directed literal sequences.
module tb_stream_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = '0;
  logic        din_val = 1'b0;
  logic        dout_rdy = 1'b1;

  logic [3:0]  dout_l, dout_m;
  logic        val_l, val_m, rdy_l, rdy_m, last_l, last_m, busy_l, busy_m;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = -1;
  int n;

  logic [3:0] q_l[$];
  logic [3:0] q_m[$];
  logic [3:0] gl[$];
  logic [3:0] gm[$];
  bit         glast[$];
  int         gc[$];

  always #5 clk = ~clk;

  stream_serializer #(.DataWidth(16), .OutWidth(4), .LsbFirst(1'b1)) u_lsb (
    .clk_i(clk), .arst_i(rst), .din_i(din), .din_val_i(din_val), .din_rdy_o(rdy_l),
    .dout_o(dout_l), .dout_val_o(val_l), .dout_rdy_i(dout_rdy), .dout_last_o(last_l),
    .busy_o(busy_l)
  );

  stream_serializer #(.DataWidth(16), .OutWidth(4), .LsbFirst(1'b0)) u_msb (
    .clk_i(clk), .arst_i(rst), .din_i(din), .din_val_i(din_val), .din_rdy_o(rdy_m),
    .dout_o(dout_m), .dout_val_o(val_m), .dout_rdy_i(dout_rdy), .dout_last_o(last_m),
    .busy_o(busy_m)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: a word accepted becomes four queued beats; output is the queue head.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_l.delete();
      q_m.delete();
    end else begin
      bit ohs, erdy;
      ohs  = (q_l.size() != 0) && dout_rdy;
      erdy = (q_l.size() == 0) || (ohs && q_l.size() == 1);
      if (val_l && dout_rdy) begin
        gl.push_back(dout_l);
        gm.push_back(dout_m);
        glast.push_back(last_l);
        gc.push_back(cyc);
      end
      if (din_val && rdy_l && acc_cyc < 0) acc_cyc = cyc;
      if (ohs) begin
        void'(q_l.pop_front());
        void'(q_m.pop_front());
      end
      if (din_val && erdy) begin
        for (int i = 0; i < 4; i++) begin
          q_l.push_back(din[4*i +: 4]);
          q_m.push_back(din[4*(3-i) +: 4]);
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_val", 32'(val_l), 32'd0);
      chk("rst_rdy", 32'(rdy_l), 32'd1);
    end else begin
      n = q_l.size();
      chk("val_l",  32'(val_l),  32'(n != 0));
      chk("val_m",  32'(val_m),  32'(n != 0));
      chk("busy_l", 32'(busy_l), 32'(n != 0));
      chk("last_l", 32'(last_l), 32'(n == 1));
      chk("last_m", 32'(last_m), 32'(n == 1));
      chk("rdy_l",  32'(rdy_l),  32'((n == 0) || (dout_rdy && n == 1)));
      chk("rdy_m",  32'(rdy_m),  32'((n == 0) || (dout_rdy && n == 1)));
      if (n != 0) begin
        chk("dout_l", 32'(dout_l), 32'(q_l[0]));
        chk("dout_m", 32'(dout_m), 32'(q_m[0]));
      end
    end
  end

  task automatic clear_got();
    gl.delete();
    gm.delete();
    glast.delete();
    gc.delete();
    acc_cyc = -1;
  endtask

  task automatic send(input logic [15:0] w);
    bit ok;
    int tries;
    tries = 0;
    din = w;
    din_val = 1'b1;
    forever begin
      @(negedge clk);
      ok = rdy_l;
      @(posedge clk);
      #1;
      if (ok) break;
      tries++;
      if (tries > 50) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    din_val = 1'b0;
  endtask

  // exp holds the expected beats left to right, first beat in the top nibble.
  task automatic chk_seq(input string name, input bit msb, input int cnt,
                         input logic [31:0] exp, input bit contig);
    chk({name, "_count"}, 32'(gl.size()), 32'(cnt));
    for (int i = 0; i < cnt && i < gl.size(); i++) begin
      chk($sformatf("%s_beat%0d", name, i), 32'(msb ? gm[i] : gl[i]), 32'(exp[4*(cnt-1-i) +: 4]));
      chk($sformatf("%s_last%0d", name, i), 32'(glast[i]), 32'(i % 4 == 3));
      if (contig && i > 0) chk($sformatf("%s_gap%0d", name, i), 32'(gc[i]), 32'(gc[i-1] + 1));
    end
  endtask

  initial begin
    #3;
    chk("reset_dout_l", 32'(dout_l), 32'd0);
    chk("reset_dout_m", 32'(dout_m), 32'd0);
    chk("reset_val",    32'(val_l),  32'd0);
    chk("reset_last",   32'(last_l), 32'd0);
    chk("reset_busy",   32'(busy_l), 32'd0);
    chk("reset_rdy",    32'(rdy_l),  32'd1);
    #4 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    clear_got();
    send(16'hA5C3);
    repeat (6) @(posedge clk);
    #1;
    chk_seq("single_lsb", 1'b0, 4, 32'h3C5A, 1'b1);
    chk_seq("single_msb", 1'b1, 4, 32'hA5C3, 1'b1);
    if (gc.size() > 0) chk("first_beat_latency", 32'(gc[0]), 32'(acc_cyc + 1));
    else chk("first_beat_seen", 32'd0, 32'd1);

    clear_got();
    send(16'h1234);
    send(16'hABCD);
    repeat (8) @(posedge clk);
    #1;
    chk_seq("b2b", 1'b0, 8, 32'h4321DCBA, 1'b1);

    clear_got();
    send(16'h7E21);
    @(posedge clk);
    #1;
    dout_rdy = 1'b0;
    din = 16'h0BAD;
    din_val = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_dout", 32'(dout_l), 32'h2);
      chk("stall_rdy",  32'(rdy_l),  32'd0);
      chk("stall_val",  32'(val_l),  32'd1);
    end
    @(posedge clk);
    #1;
    dout_rdy = 1'b1;
    send(16'h0BAD);
    repeat (6) @(posedge clk);
    #1;
    chk_seq("backpressure", 1'b0, 8, 32'h12E7DAB0, 1'b0);

    clear_got();
    send(16'hBEEF);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_val",  32'(val_l),  32'd0);
    chk("midrst_last", 32'(last_l), 32'd0);
    chk("midrst_busy", 32'(busy_l), 32'd0);
    chk("midrst_rdy",  32'(rdy_l),  32'd1);
    chk("midrst_dout", 32'(dout_l), 32'd0);
    clear_got();
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("no_residual_beats", 32'(gl.size()), 32'd0);
    clear_got();
    send(16'h00F1);
    repeat (6) @(posedge clk);
    #1;
    chk_seq("after_rst_lsb", 1'b0, 4, 32'h1F00, 1'b1);
    chk_seq("after_rst_msb", 1'b1, 4, 32'h00F1, 1'b1);

    repeat (400) begin
      @(posedge clk);
      #1;
      din      = 16'($urandom);
      din_val  = ($urandom_range(0, 3) != 0);
      dout_rdy = ($urandom_range(0, 3) != 0);
    end
    din_val  = 1'b0;
    dout_rdy = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("drain_idle_val", 32'(val_l),  32'd0);
    chk("drain_idle_busy", 32'(busy_m), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
